// File: rtl/usart_host_bridge_pkg.sv
// Shared types and constants for the i8251 host bridge: controller/bus state
// encodings and the fixed i8251 reset/internal-reset command words.
package usart_host_bridge_pkg;

    typedef enum logic [2:0] {
        RST0,
        RST1,
        RST2,
        RST_INT,
        MODE,
        CMD,
        RUN
    } fsm_state_t;

    typedef enum logic [1:0] {
        SETUP,
        STROBE,
        HOLD,
        GAP
    } bus_state_t;

    localparam logic [7:0] I8251_RST_WORD = 8'h00;
    localparam logic [7:0] I8251_IRESET   = 8'h40;

    function automatic fsm_state_t next_init_state(input fsm_state_t s);
        case (s)
            RST0:    return RST1;
            RST1:    return RST2;
            RST2:    return RST_INT;
            RST_INT: return MODE;
            MODE:    return CMD;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; the head
// entry reads as zero while empty. Push on a full FIFO succeeds only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/usart_host_bridge.sv
// Programs an i8251 after reset, then moves bytes between two host streams and
// the USART's parallel bus. Every access is setup / strobe / hold / gap.
module usart_host_bridge
    import usart_host_bridge_pkg::*;
#(
    parameter logic [7:0] MODE_BYTE  = 8'h4E,
    parameter logic [7:0] CMD_BYTE   = 8'h37,
    parameter int         STROBE_LEN = 2,
    parameter int         GAP_LEN    = 2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          init_done,
    output logic                          CS_n,
    output logic                          WR_n,
    output logic                          RD_n,
    output logic                          CD,
    output logic [7:0]                    D_o,
    input  logic [7:0]                    D_i,
    output logic                          D_oe,
    input  logic                          RxRDY,
    input  logic                          TxRDY,
    output fsm_state_t                    fsm_state,
    output bus_state_t                    bus_state,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);
    localparam logic [3:0] GAP_LAST    = 4'(GAP_LEN - 1);

    fsm_state_t state_q, state_d;
    bus_state_t bus_q, bus_d;
    logic       busy_q, busy_d;
    logic       is_rd_q, is_rd_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rd_q;
    logic [7:0] tx_head;
    logic [7:0] wr_word;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       in_access, capture, tx_pop, rx_push;

    // busy_q low means no access in flight: after reset (SETUP pending) or idle in RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RST0;
            bus_q   <= SETUP;
            busy_q  <= 1'b0;
            is_rd_q <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            busy_q  <= busy_d;
            is_rd_q <= is_rd_d;
            cnt_q   <= cnt_d;
            if (capture) rd_q <= D_i;
        end
    end

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        busy_d  = busy_q;
        is_rd_d = is_rd_q;
        cnt_d   = cnt_q;
        if (!busy_q) begin
            if (state_q != RUN) begin
                busy_d  = 1'b1;
                bus_d   = SETUP;
                is_rd_d = 1'b0;
            end else if (RxRDY && !rx_full) begin
                busy_d  = 1'b1;
                bus_d   = SETUP;
                is_rd_d = 1'b1;
            end else if (TxRDY && !tx_empty) begin
                busy_d  = 1'b1;
                bus_d   = SETUP;
                is_rd_d = 1'b0;
            end
        end else begin
            case (bus_q)
                SETUP: begin
                    bus_d = STROBE;
                    cnt_d = '0;
                end
                STROBE: begin
                    if (cnt_q == STROBE_LAST) bus_d = HOLD;
                    else                      cnt_d = cnt_q + 4'd1;
                end
                HOLD: begin
                    bus_d = GAP;
                    cnt_d = '0;
                end
                default: begin
                    if (cnt_q == GAP_LAST) begin
                        bus_d = SETUP;
                        cnt_d = '0;
                        // Init writes chain back to back; RUN re-arbitrates in an idle cycle.
                        if (state_q == RUN || state_q == CMD) busy_d = 1'b0;
                        if (state_q != RUN) state_d = next_init_state(state_q);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            RST_INT: wr_word = I8251_IRESET;
            MODE:    wr_word = MODE_BYTE;
            CMD:     wr_word = CMD_BYTE;
            RUN:     wr_word = tx_head;
            default: wr_word = I8251_RST_WORD;
        endcase
    end

    assign in_access = busy_q && (bus_q != GAP);
    assign capture   = busy_q && is_rd_q && (bus_q == STROBE) && (cnt_q == STROBE_LAST);
    assign tx_pop    = (state_q == RUN) && busy_q && (bus_q == HOLD) && !is_rd_q;
    assign rx_push   = (state_q == RUN) && busy_q && (bus_q == HOLD) && is_rd_q;

    assign CS_n      = !in_access;
    assign WR_n      = !(busy_q && (bus_q == STROBE) && !is_rd_q);
    assign RD_n      = !(busy_q && (bus_q == STROBE) && is_rd_q);
    assign CD        = in_access && (state_q != RUN);
    assign D_oe      = in_access && !is_rd_q;
    assign D_o       = D_oe ? wr_word : 8'h00;
    assign init_done = (state_q == RUN);
    assign tx_ready  = !tx_full;
    assign rx_valid  = !rx_empty;
    assign fsm_state = state_q;
    assign bus_state = bus_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (tx_valid && !tx_full),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (rx_push),
        .push_data (rd_q),
        .pop       (rx_ready && !rx_empty),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_level)
    );

endmodule

// File: tb/tb_usart_host_bridge.sv
// Bench for usart_host_bridge: bus monitor checks strobe/gap timing and
// written words against a scoreboard queue; read data is checked on the host side.
module tb_usart_host_bridge;
    import usart_host_bridge_pkg::*;

    localparam int STROBE_LEN = 2;
    localparam int GAP_LEN    = 2;
    localparam int FIFO_DEPTH = 4;

    logic       CLK;
    logic       RESET;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       init_done;
    logic       CS_n, WR_n, RD_n, CD;
    logic [7:0] D_o;
    logic [7:0] D_i;
    logic       D_oe;
    logic       RxRDY, TxRDY;
    fsm_state_t fsm_state;
    bus_state_t bus_state;
    logic [2:0] tx_level, rx_level;

    logic [8:0] exp_q[$];
    logic [7:0] rx_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int rd_count = 0;

    usart_host_bridge #(
        .MODE_BYTE(8'h4E), .CMD_BYTE(8'h37), .STROBE_LEN(STROBE_LEN),
        .GAP_LEN(GAP_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done),
        .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .CD(CD),
        .D_o(D_o), .D_i(D_i), .D_oe(D_oe),
        .RxRDY(RxRDY), .TxRDY(TxRDY),
        .fsm_state(fsm_state), .bus_state(bus_state),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        int cyc, wr_len, rd_len, gap_len, last_hold_cyc;
        logic [8:0] wr_word;
        logic [7:0] rd_word;
        logic seen_access, prev_init;
        cyc = 0; wr_len = 0; rd_len = 0; gap_len = 0; last_hold_cyc = 0;
        wr_word = '0; rd_word = '0; seen_access = 0; prev_init = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET) begin
                wr_len = 0; rd_len = 0; gap_len = 0;
                seen_access = 0; prev_init = 0;
            end else begin
                if (!WR_n) begin
                    wr_len++;
                    wr_word = {CD, D_o};
                end else if (wr_len != 0) begin
                    check("wr_strobe_len", wr_len, STROBE_LEN);
                    check("wr_hold_cs", CS_n, 0);
                    check("wr_hold_oe", D_oe, 1);
                    if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
                    else check("wr_word", wr_word, exp_q.pop_front());
                    wr_count++;
                    last_hold_cyc = cyc;
                    wr_len = 0;
                end
                if (!RD_n) begin
                    rd_len++;
                    rd_word = D_i;
                end else if (rd_len != 0) begin
                    check("rd_strobe_len", rd_len, STROBE_LEN);
                    check("rd_hold_oe", D_oe, 0);
                    rx_q.push_back(rd_word);
                    rd_count++;
                    rd_len = 0;
                end
                if (CS_n) gap_len++;
                else begin
                    if (seen_access && gap_len != 0) check("gap_len_min", gap_len >= GAP_LEN, 1);
                    gap_len = 0;
                    seen_access = 1;
                end
                if (init_done && !prev_init)
                    check("init_done_timing", cyc - last_hold_cyc, GAP_LEN + 1);
                prev_init = init_done;
            end
        end
    end

    task automatic expect_init();
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h40});
        exp_q.push_back({1'b1, 8'h4E});
        exp_q.push_back({1'b1, 8'h37});
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && n < budget) begin @(negedge CLK); n++; end
        check("init_done", init_done, 1);
    endtask

    task automatic push_tx(input logic [7:0] b, input int budget);
        int n = 0;
        @(negedge CLK);
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < budget) begin @(negedge CLK); n++; end
        if (!tx_ready) check("tx_push_timeout", 0, 1);
        else begin
            exp_q.push_back({1'b0, b});
            @(posedge CLK);
        end
        #1 tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input int budget);
        int n = 0;
        @(negedge CLK);
        while (!rx_valid && n < budget) begin @(negedge CLK); n++; end
        if (!rx_valid) check("rx_pop_timeout", 0, 1);
        else begin
            if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
            else check("rx_data", rx_data, rx_q.pop_front());
            rx_ready = 1'b1;
            @(posedge CLK);
            #1 rx_ready = 1'b0;
        end
    endtask

    task automatic wait_tx_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge CLK); n++; end
        check("tx_drain", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, n;
        RESET = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        D_i = '0; RxRDY = 1'b0; TxRDY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_cs_n", CS_n, 1);
        check("rst_strobes", {WR_n, RD_n}, 2'b11);
        check("rst_cd_do_oe", {CD, D_o, D_oe}, 0);
        check("rst_init_done", init_done, 0);
        check("rst_rx", {rx_valid, rx_data}, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_fsm", fsm_state, RST0);
        check("rst_bus", bus_state, SETUP);
        check("rst_levels", {tx_level, rx_level}, 0);

        // Programming sequence
        expect_init();
        RESET = 1'b0;
        wait_init(200);
        check("init_words_left", exp_q.size(), 0);
        check("init_write_count", wr_count, 6);

        // Single tx byte
        base = wr_count;
        TxRDY = 1'b1;
        push_tx(8'hA5, 20);
        @(negedge CLK);
        check("tx_ready_after_push", tx_ready, 1);
        wait_tx_drain(100);
        check("tx_single_write", wr_count - base, 1);
        TxRDY = 1'b0;

        // Fill the rx FIFO; the bridge must stop reading when full
        base = rd_count;
        D_i = 8'h3C;
        RxRDY = 1'b1;
        n = 0;
        while (rd_count - base < 4 && n < 200) begin @(negedge CLK); n++; end
        repeat (40) @(negedge CLK);
        check("rx_fill_reads", rd_count - base, 4);
        check("rx_full_valid", rx_valid, 1);
        check("rx_full_data", rx_data, 8'h3C);
        check("rx_full_level", rx_level, 4);
        check("rx_full_bus_idle", CS_n, 1);
        RxRDY = 1'b0;
        repeat (4) pop_rx(20);
        @(negedge CLK);
        check("rx_drained", rx_valid, 0);

        // Read has priority over write
        push_tx(8'h77, 20);
        D_i = 8'h5A;
        @(negedge CLK);
        RxRDY = 1'b1;
        TxRDY = 1'b1;
        n = 0;
        while (RD_n && WR_n && n < 50) begin @(negedge CLK); n++; end
        check("first_access_read", {RD_n, WR_n}, 2'b01);
        RxRDY = 1'b0;
        n = 0;
        while (WR_n && n < 50) begin @(negedge CLK); n++; end
        check("then_write", WR_n, 0);
        wait_tx_drain(100);
        TxRDY = 1'b0;
        pop_rx(50);

        // Fill the tx FIFO with random bytes; the fifth waits for a pop
        for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(0, 255)), 20);
        @(negedge CLK);
        check("tx_full_ready", tx_ready, 0);
        check("tx_full_level", tx_level, 4);
        TxRDY = 1'b1;
        push_tx(8'($urandom_range(0, 255)), 200);
        wait_tx_drain(400);
        TxRDY = 1'b0;

        // Reset in the middle of a data write strobe
        push_tx(8'hB1, 20);
        @(negedge CLK);
        TxRDY = 1'b1;
        n = 0;
        while (WR_n && n < 50) begin @(negedge CLK); n++; end
        check("abort_in_strobe", WR_n, 0);
        #2 RESET = 1'b1;
        #1;
        check("abort_wr_n", WR_n, 1);
        check("abort_oe", D_oe, 0);
        check("abort_cs_n", CS_n, 1);
        exp_q.delete();
        TxRDY = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_tx_level", tx_level, 0);
        check("abort_fsm", fsm_state, RST0);
        expect_init();
        RESET = 1'b0;
        wait_init(200);
        check("reinit_words_left", exp_q.size(), 0);
        check("reinit_tx_level", tx_level, 0);
        base = wr_count;
        TxRDY = 1'b1;
        repeat (30) @(negedge CLK);
        check("no_write_after_abort", wr_count - base, 0);
        TxRDY = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
